mlp_param_loader: RTL and testbench
===================================

Name: mlp_param_loader

Overview:
- Run-time loader for the MLP classifier's parameter buses. The classifier currently receives weights and biases as constant buses.
- Receives a byte stream over a valid/ready handshake and assembles it into the flat `weights` and `biases` buses in the exact layout the classifier `top` consumes.
- Verifies a trailing XOR checksum, then commits the new parameter set to the active output registers in a single cycle.
- Sits between the host/serial front end and the classifier's weights/biases ports.

Parameters:
- NUM_W, 21, number of weights.
- WIDTH_W, 8, weight width in bits (1..16).
- NUM_B0, 3, number of hidden-layer biases.
- WIDTH_B0, 12, hidden bias width (1..16).
- NUM_B1, 3, number of output-layer biases.
- WIDTH_B1, 16, output bias width (1..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins (or restarts) a load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- weights  out  NUM_W*WIDTH_W  active weights; weight k at bits [(k+1)*WIDTH_W-1 : k*WIDTH_W]
- biases  out  NUM_B0*WIDTH_B0+NUM_B1*WIDTH_B1  active biases; B0[0] at the LSBs, then B0[1..], then B1[0..] toward the MSBs
- params_valid  out  1  high once at least one load has committed
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful commit
- err  out  1  one-cycle pulse on checksum mismatch

Behaviour:
- Reset (asynchronous, active-low): state IDLE; weights=0, biases=0; params_valid=0, busy=0, done=0, err=0, in_ready=0; shadow registers, counters and checksum cleared.
- Byte accepted only when in_valid && in_ready.
- Stream format:
  - Each parameter is sent as BYTES=ceil(WIDTH/8) bytes, least-significant byte first.
  - Bits above WIDTH in the last byte are ignored (truncated) but still included in the checksum.
  - Order: weights 0..NUM_W-1, then B0 0..NUM_B0-1, then B1 0..NUM_B1-1, then one checksum byte.
  - Checksum = XOR of all preceding payload bytes.
  - Default payload: 21 + 6 + 6 = 33 bytes, plus checksum = 34 bytes total.
- FSM states: IDLE, LOAD, CHECK, COMMIT.
  - IDLE: in_ready=0; start -> LOAD, with param index, byte index and running XOR cleared.
  - LOAD: in_ready=1.
    - Each accepted byte is written into the shadow slice for the current parameter/byte and XORed into the running checksum.
    - The byte index wraps to 0 at BYTES-1 and the param index then increments.
    - Accepting the last byte of the last B1 moves to CHECK.
  - CHECK: in_ready=1.
    - On an accepted byte equal to the running XOR: -> COMMIT.
    - On mismatch: err pulses the next cycle, state -> IDLE, active registers unchanged.
  - COMMIT (one cycle, in_ready=0): shadow copied to weights/biases; params_valid<=1; done pulses in the same cycle the outputs change; then -> IDLE.
- Latency: the outputs update exactly 1 cycle after the cycle in which the checksum byte is accepted.
- start while LOAD or CHECK: abort and restart. Counters and XOR are cleared, the shadow contents are don't-care, and the active outputs are unchanged. A byte presented in the same cycle as start is not accepted.
- start during COMMIT: ignored.
- in_valid gaps are allowed anywhere; state and counters hold.
- Outputs never show a partial parameter set. They change only in COMMIT or on reset.
- Reset asserted mid-load clears everything, including previously committed parameters.

Decomposition:
- Package mlp_param_pkg:
  - byte-count function ceil(w/8);
  - total payload byte count;
  - FSM state enum;
  - default NUM_*/WIDTH_* constants for the Iris design.
- One natural sub-module, param_shadow_bank: holds the shadow register array written by (param index, byte index, data) and the commit copy to the active registers.
- The FSM, counters and checksum stay in the top-level block.

Test Plan:
- Full load of weights [75,-42,-55,-75,-13,-69,-105,30,71,31,108,-1,-15,18,5,-7,0,-57,-62,48,-29] and biases B0=[639,-698,-1112], B1=[-11255,17487,-17315], with a correct checksum -> the weights bus equals the corresponding 168-bit concatenation; biases = {16'hBC5D, 16'h444F, 16'hD409, 12'hBA8, 12'hD46, 12'h27F}; done=1 for one cycle, 1 cycle after the checksum byte; params_valid=1.
- Same stream with the checksum XORed with 8'h01 -> err pulses once, done never pulses, weights/biases/params_valid remain at their prior values (0 from reset).
- Bias -1112 sent as bytes 8'hA8, 8'hFB versus 8'hA8, 8'h0B (checksum adjusted in each case) -> both loads commit with the B0[2] slice = 12'hBA8 (upper nibble truncated).
- Random in_valid gaps of 0-5 cycles during the full load -> result identical to the gap-free load; in_ready is low in IDLE and COMMIT.
- After a good load, start again, send 10 bytes, then start again and send a complete new set -> the outputs hold the first set until the second commit and never show a mixture of the two.
- rst_n pulled low mid-load after a prior commit -> all outputs are 0 immediately (asynchronously), params_valid=0, and the FSM is in IDLE on release.

Source files
------------

// File: rtl/mlp_param_pkg.sv
// Shared constants and helpers for the MLP parameter loader.
// Defaults match the Iris classifier build.
package mlp_param_pkg;

  localparam int NUM_W_D    = 21;
  localparam int WIDTH_W_D  = 8;
  localparam int NUM_B0_D   = 3;
  localparam int WIDTH_B0_D = 12;
  localparam int NUM_B1_D   = 3;
  localparam int WIDTH_B1_D = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int payload_bytes(
    input int nw,
    input int ww,
    input int nb0,
    input int wb0,
    input int nb1,
    input int wb1
  );
    return nw * nbytes(ww) + nb0 * nbytes(wb0)
         + nb1 * nbytes(wb1);
  endfunction

  // Parameters are at most 16 bits, so every one fits two byte lanes.
  function automatic logic [15:0] put_byte(
    input logic [15:0] v,
    input logic        hi,
    input logic [7:0]  d
  );
    return hi ? {d, v[7:0]} : {v[15:8], d};
  endfunction

endpackage

// File: rtl/mlp_param_loader_shadow.sv
// Shadow parameter bank plus the active registers it commits into.
// Bytes land in the shadow slot selected by parameter and byte index.
module param_shadow_bank
  import mlp_param_pkg::*;
#(
  parameter int NUM_W    = NUM_W_D,
  parameter int WIDTH_W  = WIDTH_W_D,
  parameter int NUM_B0   = NUM_B0_D,
  parameter int WIDTH_B0 = WIDTH_B0_D,
  parameter int NUM_B1   = NUM_B1_D,
  parameter int WIDTH_B1 = WIDTH_B1_D,
  parameter int PW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [PW-1:0] pidx_i,
  input  logic          bidx_i,
  input  logic [7:0]    data_i,
  input  logic          commit_i,
  output logic [NUM_W*WIDTH_W-1:0] weights_o,
  output logic [NUM_B0*WIDTH_B0+NUM_B1*WIDTH_B1-1:0] biases_o
);

  localparam int B0_BITS = NUM_B0 * WIDTH_B0;
  localparam int B_BITS  = B0_BITS + NUM_B1 * WIDTH_B1;

  logic [WIDTH_W-1:0]  w_q  [NUM_W];
  logic [WIDTH_B0-1:0] b0_q [NUM_B0];
  logic [WIDTH_B1-1:0] b1_q [NUM_B1];

  logic [NUM_W*WIDTH_W-1:0] w_flat, weights_q;
  logic [B_BITS-1:0]        b_flat, biases_q;

  for (genvar k = 0; k < NUM_W; k++) begin : g_w
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_q[k] <= '0;
      end else if (we_i && pidx_i == PW'(k)) begin
        w_q[k] <= WIDTH_W'(
          put_byte(16'(w_q[k]), bidx_i, data_i));
      end
    end
    assign w_flat[k*WIDTH_W +: WIDTH_W] = w_q[k];
  end

  for (genvar k = 0; k < NUM_B0; k++) begin : g_b0
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        b0_q[k] <= '0;
      end else if (we_i && pidx_i == PW'(NUM_W + k)) begin
        b0_q[k] <= WIDTH_B0'(
          put_byte(16'(b0_q[k]), bidx_i, data_i));
      end
    end
    assign b_flat[k*WIDTH_B0 +: WIDTH_B0] = b0_q[k];
  end

  for (genvar k = 0; k < NUM_B1; k++) begin : g_b1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        b1_q[k] <= '0;
      end else if (we_i &&
                   pidx_i == PW'(NUM_W + NUM_B0 + k)) begin
        b1_q[k] <= WIDTH_B1'(
          put_byte(16'(b1_q[k]), bidx_i, data_i));
      end
    end
    assign b_flat[B0_BITS+k*WIDTH_B1 +: WIDTH_B1] = b1_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_q <= '0;
      biases_q  <= '0;
    end else if (commit_i) begin
      weights_q <= w_flat;
      biases_q  <= b_flat;
    end
  end

  assign weights_o = weights_q;
  assign biases_o  = biases_q;

endmodule

// File: rtl/mlp_param_loader.sv
// Byte-stream loader for the MLP weight/bias buses.
// Checksum-verified, committed to the active set in one cycle.
module mlp_param_loader
  import mlp_param_pkg::*;
#(
  parameter int NUM_W    = NUM_W_D,
  parameter int WIDTH_W  = WIDTH_W_D,
  parameter int NUM_B0   = NUM_B0_D,
  parameter int WIDTH_B0 = WIDTH_B0_D,
  parameter int NUM_B1   = NUM_B1_D,
  parameter int WIDTH_B1 = WIDTH_B1_D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [NUM_W*WIDTH_W-1:0] weights,
  output logic [NUM_B0*WIDTH_B0+NUM_B1*WIDTH_B1-1:0] biases,
  output logic       params_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int NP    = NUM_W + NUM_B0 + NUM_B1;
  localparam int PW    = $clog2(NP + 1);
  localparam int BY_W  = nbytes(WIDTH_W);
  localparam int BY_B0 = nbytes(WIDTH_B0);
  localparam int BY_B1 = nbytes(WIDTH_B1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pidx_q, pidx_d;
  logic          bidx_q, bidx_d;
  logic [7:0]    xor_q, xor_d;
  logic          done_q, err_q, pv_q;
  logic          accept, match, commit;
  logic          last_b, last_p;

  assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  // A byte coinciding with start belongs to the aborted load.
  assign accept   = in_valid && in_ready && !start;
  assign match    = (in_data == xor_q);
  assign last_p   = (pidx_q == PW'(NP - 1));
  assign commit   = (state_q == S_CHECK) && accept && match;

  always_comb begin
    last_b = (bidx_q == 1'(BY_B1 - 1));
    if (pidx_q < PW'(NUM_W))
      last_b = (bidx_q == 1'(BY_W - 1));
    else if (pidx_q < PW'(NUM_W + NUM_B0))
      last_b = (bidx_q == 1'(BY_B0 - 1));
  end

  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    bidx_d  = bidx_q;
    xor_d   = xor_q;
    unique case (state_q)
      S_IDLE, S_LOAD, S_CHECK: begin
        if (start) begin
          state_d = S_LOAD;
          pidx_d  = '0;
          bidx_d  = 1'b0;
          xor_d   = '0;
        end else if (accept && state_q == S_CHECK) begin
          state_d = match ? S_COMMIT : S_IDLE;
        end else if (accept) begin
          xor_d = xor_q ^ in_data;
          if (last_b) begin
            bidx_d = 1'b0;
            if (last_p) state_d = S_CHECK;
            else        pidx_d  = pidx_q + 1'b1;
          end else begin
            bidx_d = 1'b1;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pidx_q  <= '0;
      bidx_q  <= 1'b0;
      xor_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
      bidx_q  <= bidx_d;
      xor_q   <= xor_d;
      done_q  <= commit;
      err_q   <= (state_q == S_CHECK) && accept && !match;
      if (commit) pv_q <= 1'b1;
    end
  end

  param_shadow_bank #(
    .NUM_W    (NUM_W),
    .WIDTH_W  (WIDTH_W),
    .NUM_B0   (NUM_B0),
    .WIDTH_B0 (WIDTH_B0),
    .NUM_B1   (NUM_B1),
    .WIDTH_B1 (WIDTH_B1),
    .PW       (PW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      ((state_q == S_LOAD) && accept),
    .pidx_i    (pidx_q),
    .bidx_i    (bidx_q),
    .data_i    (in_data),
    .commit_i  (commit),
    .weights_o (weights),
    .biases_o  (biases)
  );

  assign params_valid = pv_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mlp_param_loader.sv
// Directed bench for mlp_param_loader.
// Byte streams built in-bench, expectations hand-derived.
module tb_mlp_param_loader;
  import mlp_param_pkg::*;

  localparam int NB = payload_bytes(21, 8, 3, 12, 3, 16) + 1;
  localparam logic [71:0] EB_A = {16'hBC5D, 16'h444F, 16'hD409,
                                  12'hBA8, 12'hD46, 12'h27F};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [167:0] weights;
  logic [71:0]  biases;
  logic         params_valid, busy, done, err;

  always #5 clk = ~clk;

  mlp_param_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .weights      (weights),
    .biases       (biases),
    .params_valid (params_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int wv [21] = '{75, -42, -55, -75, -13, -69, -105, 30, 71, 31,
                  108, -1, -15, 18, 5, -7, 0, -57, -62, 48, -29};
  int b0v [3] = '{639, -698, -1112};
  int b1v [3] = '{-11255, 17487, -17315};

  logic [7:0]   s [NB];
  logic [167:0] ew_a, ew_b;
  logic [71:0]  eb_b;
  int n_chk = 0, n_err = 0;
  int done_cnt = 0, err_cnt = 0, mix_bad = 0;
  int d0, e0;
  logic mix_on = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mix_on && {weights, biases} != {ew_a, EB_A}
               && {weights, biases} != {ew_b, eb_b})
      mix_bad++;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic fix_cks();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB - 1; i++) x ^= s[i];
    s[NB-1] = x;
  endtask

  task automatic build_a();
    for (int k = 0; k < 21; k++) s[k] = 8'(wv[k]);
    for (int j = 0; j < 3; j++) begin
      s[21+2*j] = 8'(b0v[j]);
      s[22+2*j] = 8'(b0v[j] >>> 8);
      s[27+2*j] = 8'(b1v[j]);
      s[28+2*j] = 8'(b1v[j] >>> 8);
    end
    fix_cks();
  endtask

  task automatic build_b();
    build_a();
    for (int i = 0; i < NB - 1; i++) s[i] ^= 8'h33;
    fix_cks();
  endtask

  task automatic model(output logic [167:0] ew,
                       output logic [71:0] eb);
    for (int k = 0; k < 21; k++) ew[k*8 +: 8] = s[k];
    for (int j = 0; j < 3; j++) begin
      eb[j*12 +: 12] = {s[22+2*j][3:0], s[21+2*j]};
      eb[36+j*16 +: 16] = {s[28+2*j], s[27+2*j]};
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int from, input int n, input int gap);
    int cnt;
    for (int i = from; i < from + n; i++) begin
      repeat ($urandom_range(gap, 0)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      cnt = 0;
      while (!in_ready && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic good_load(input string tag, input int gap,
                           input logic [167:0] ew,
                           input logic [71:0] eb);
    pulse_start();
    send(0, NB, gap);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_w"}, weights, ew);
    chk({tag, "_b"}, biases, eb);
    chk({tag, "_pv"}, params_valid, 1);
    @(posedge clk); #1;
    chk({tag, "_done_end"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w", weights, 0);
    chk("rst_b", biases, 0);
    chk("rst_pv", params_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", in_ready, 0);

    // corrupted checksum from reset state
    build_a();
    s[NB-1] ^= 8'h01;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start();
    chk("load_busy", busy, 1);
    chk("load_rdy", in_ready, 1);
    send(0, NB, 0);
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    @(posedge clk); #1;
    chk("bad_err_end", err, 0);
    chk("bad_err_cnt", err_cnt - e0, 1);
    chk("bad_done_cnt", done_cnt - d0, 0);
    chk("bad_w", weights, 0);
    chk("bad_b", biases, 0);
    chk("bad_pv", params_valid, 0);
    chk("bad_busy", busy, 0);

    // good load A, commit cycle details
    build_a();
    model(ew_a, eb_b);
    d0 = done_cnt;
    pulse_start();
    send(0, NB, 0);
    chk("a_done", done, 1);
    chk("a_w", weights, ew_a);
    chk("a_b", biases, EB_A);
    chk("a_pv", params_valid, 1);
    chk("commit_rdy", in_ready, 0);
    chk("commit_busy", busy, 1);
    @(posedge clk); #1;
    chk("a_done_end", done, 0);
    chk("a_done_cnt", done_cnt - d0, 1);
    chk("a_busy_end", busy, 0);
    chk("a_rdy_end", in_ready, 0);

    // set B, then A with upper nibble 0 instead of F
    build_b();
    model(ew_b, eb_b);
    good_load("b", 0, ew_b, eb_b);
    build_a();
    s[26] = 8'h0B;
    fix_cks();
    good_load("trunc", 0, ew_a, EB_A);

    // random in_valid gaps
    build_b();
    good_load("gap_b", 5, ew_b, eb_b);
    build_a();
    good_load("gap_a", 5, ew_a, EB_A);

    // abort twice, then load B; no mixed output ever
    mix_on = 1'b1;
    build_b();
    pulse_start();
    send(0, 10, 0);
    chk("abort_w", weights, ew_a);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    pulse_start();
    in_valid = 1'b0;
    send(0, NB - 1, 2);
    chk("hold_w", weights, ew_a);
    chk("hold_b", biases, EB_A);
    send(NB - 1, 1, 0);
    chk("swap_done", done, 1);
    chk("swap_w", weights, ew_b);
    chk("swap_b", biases, eb_b);
    @(posedge clk); #1;
    mix_on = 1'b0;
    chk("no_mix", mix_bad, 0);

    // async reset mid-load after a commit
    pulse_start();
    send(0, 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_w", weights, 0);
    chk("arst_b", biases, 0);
    chk("arst_pv", params_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_busy", busy, 0);
    chk("rel_rdy", in_ready, 0);
    chk("rel_pv", params_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
